// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: opcodes and FSM states.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_DIVU  = 2'b01,
        MD_MTHI  = 2'b10,
        MD_MTLO  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step,
// operating on shared working registers (acc/rem in work_hi, mplr/quo in work_lo).
module muldiv_step #(
    parameter int NB_DATA = 32
) (
    input  logic               div_mode,
    input  logic [NB_DATA:0]   work_hi,
    input  logic [NB_DATA-1:0] work_lo,
    input  logic [NB_DATA-1:0] work_b,
    output logic [NB_DATA:0]   next_hi,
    output logic [NB_DATA-1:0] next_lo
);

    logic [NB_DATA:0] sum;
    logic [NB_DATA:0] trial;
    logic [NB_DATA:0] divisor;
    logic             fits;

    always_comb begin
        sum     = work_hi + (work_lo[0] ? {1'b0, work_b} : '0);
        trial   = {work_hi[NB_DATA-1:0], work_lo[NB_DATA-1]};
        divisor = {1'b0, work_b};
        fits    = (trial >= divisor);
        if (div_mode) begin
            next_hi = fits ? (trial - divisor) : trial;
            next_lo = {work_lo[NB_DATA-2:0], fits};
        end else begin
            // {acc, mplr} <= {sum, mplr} >> 1
            next_hi = {1'b0, sum[NB_DATA:1]};
            next_lo = {sum[0], work_lo[NB_DATA-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU sequencer owning the architectural HI/LO registers;
// one result bit per enabled cycle, MTHI/MTLO executed in a single cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_MD_OP = 2,
    parameter int NB_COUNT = 5
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                enable_i,
    input  logic                start_i,
    input  logic [NB_MD_OP-1:0] op_i,
    input  logic [NB_DATA-1:0]  operand_a_i,
    input  logic [NB_DATA-1:0]  operand_b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                div_by_zero_o,
    output logic [NB_DATA-1:0]  hi_o,
    output logic [NB_DATA-1:0]  lo_o
);

    md_state_e            state;
    md_state_e            state_next;
    md_op_e               op;
    logic [NB_COUNT-1:0]  cnt;
    logic [NB_DATA:0]     work_hi;
    logic [NB_DATA-1:0]   work_lo;
    logic [NB_DATA-1:0]   work_b;
    logic                 dz_flag;
    logic [NB_DATA:0]     next_hi;
    logic [NB_DATA-1:0]   next_lo;

    assign op = md_op_e'(op_i);

    muldiv_step #(.NB_DATA(NB_DATA)) u_step (
        .div_mode (state == MD_DIV),
        .work_hi  (work_hi),
        .work_lo  (work_lo),
        .work_b   (work_b),
        .next_hi  (next_hi),
        .next_lo  (next_lo)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state <= MD_IDLE;
        else if (enable_i)
            state <= state_next;
    end

    // Requests arriving outside IDLE are dropped; the hazard unit prevents them.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: begin
                if (start_i) begin
                    case (op)
                        MD_MULTU: state_next = MD_MUL;
                        MD_DIVU:  state_next = (operand_b_i == '0) ? MD_DONE : MD_DIV;
                        default:  state_next = MD_IDLE;
                    endcase
                end
            end
            MD_MUL, MD_DIV: if (cnt == '0) state_next = MD_DONE;
            default:        state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state == MD_MUL) || (state == MD_DIV);
        done_o        = (state == MD_DONE);
        div_by_zero_o = (state == MD_DONE) && dz_flag;
    end

    // HI/LO only change on MTHI/MTLO or on the final iteration edge.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            work_b  <= '0;
            dz_flag <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else if (enable_i) begin
            case (state)
                MD_IDLE: begin
                    if (start_i) begin
                        case (op)
                            MD_MULTU, MD_DIVU: begin
                                work_hi <= '0;
                                work_lo <= operand_a_i;
                                work_b  <= operand_b_i;
                                cnt     <= NB_COUNT'(NB_DATA - 1);
                                dz_flag <= (op == MD_DIVU) && (operand_b_i == '0);
                            end
                            MD_MTHI: hi_o <= operand_a_i;
                            default: lo_o <= operand_a_i;
                        endcase
                    end
                end
                MD_MUL, MD_DIV: begin
                    work_hi <= next_hi;
                    work_lo <= next_lo;
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        hi_o <= next_hi[NB_DATA-1:0];
                        lo_o <= next_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: a small reference model pushes expected
// HI/LO/div-by-zero results into a scoreboard that is drained on every done pulse.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        enable_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        busy_o;
    logic        done_o;
    logic        div_by_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_unit dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .enable_i      (enable_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .operand_a_i   (operand_a_i),
        .operand_b_i   (operand_b_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock_i);
        #1;
    endtask

    // Drives a request across one edge; the model predicts the committed result.
    task automatic applyStimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] prod;
        start_i     = 1'b1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        case (op)
            MD_MULTU: begin
                prod     = {32'b0, a} * {32'b0, b};
                model_hi = prod[63:32];
                model_lo = prod[31:0];
                e.hi = model_hi; e.lo = model_lo; e.dz = 1'b0;
                sb.push_back(e);
            end
            MD_DIVU: begin
                if (b != 0) begin
                    model_hi = a % b;
                    model_lo = a / b;
                end
                e.hi = model_hi; e.lo = model_lo; e.dz = (b == 0);
                sb.push_back(e);
            end
            MD_MTHI: model_hi = a;
            default: model_lo = a;
        endcase
        nextCycle();
        start_i     = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
    endtask

    task automatic waitDone(input string tag, input int start_cycle, input int exp_cycle, input int exp_busy);
        int   cycle    = start_cycle;
        int   busy_cnt = 0;
        exp_t e;
        while (!done_o && cycle < 200) begin
            if (busy_o) busy_cnt++;
            nextCycle();
            cycle++;
        end
        checkOutput({tag, "_done_cycle"}, 64'(cycle), 64'(exp_cycle));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        checkOutput({tag, "_done"}, 64'(done_o), 64'd1);
        checkOutput({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_hi"}, 64'(hi_o), 64'(e.hi));
            checkOutput({tag, "_lo"}, 64'(lo_o), 64'(e.lo));
            checkOutput({tag, "_dz"}, 64'(div_by_zero_o), 64'(e.dz));
        end
        nextCycle();
        checkOutput({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    endtask

    initial begin
        reset_n_i   = 1'b0;
        enable_i    = 1'b1;
        start_i     = 1'b0;
        op_i        = 2'b00;
        operand_a_i = '0;
        operand_b_i = '0;
        repeat (2) nextCycle();
        checkOutput("reset_hi", 64'(hi_o), 64'd0);
        checkOutput("reset_lo", 64'(lo_o), 64'd0);
        checkOutput("reset_flags", {61'b0, busy_o, done_o, div_by_zero_o}, 64'd0);
        reset_n_i = 1'b1;
        nextCycle();

        $display("[TB] MULTU max * max");
        applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("t1_busy_c1", 64'(busy_o), 64'd1);
        waitDone("t1", 1, 33, 32);
        checkOutput("t1_hi_const", 64'(hi_o), 64'hFFFFFFFE);
        checkOutput("t1_lo_const", 64'(lo_o), 64'h1);

        $display("[TB] DIVU 100/7 and 7/100");
        applyStimulus(MD_DIVU, 32'd100, 32'd7);
        waitDone("t2a", 1, 33, 32);
        checkOutput("t2a_lo_const", 64'(lo_o), 64'd14);
        checkOutput("t2a_hi_const", 64'(hi_o), 64'd2);
        applyStimulus(MD_DIVU, 32'd7, 32'd100);
        waitDone("t2b", 1, 33, 32);

        $display("[TB] MTHI/MTLO preload then DIVU by zero");
        applyStimulus(MD_MTHI, 32'hAAAA, 32'h0);
        applyStimulus(MD_MTLO, 32'h5555, 32'h0);
        applyStimulus(MD_DIVU, 32'd5, 32'd0);
        waitDone("t3", 1, 1, 0);
        checkOutput("t3_hi_const", 64'(hi_o), 64'hAAAA);

        $display("[TB] MTHI single-cycle write");
        applyStimulus(MD_MTHI, 32'h12345678, 32'h0);
        checkOutput("t4_hi", 64'(hi_o), 64'h12345678);
        checkOutput("t4_lo", 64'(lo_o), 64'(model_lo));
        checkOutput("t4_flags", {62'b0, busy_o, done_o}, 64'd0);
        nextCycle();
        checkOutput("t4_flags_next", {62'b0, busy_o, done_o}, 64'd0);

        $display("[TB] MULTU with enable stall and stray start");
        applyStimulus(MD_MULTU, 32'd3, 32'd5);
        repeat (9) nextCycle();
        enable_i = 1'b0;
        repeat (5) begin
            nextCycle();
            checkOutput("t5_frozen_busy", {62'b0, busy_o, done_o}, 64'b10);
            checkOutput("t5_frozen_hi", 64'(hi_o), 64'h12345678);
        end
        enable_i    = 1'b1;
        start_i     = 1'b1;
        op_i        = MD_MULTU;
        operand_a_i = 32'd9;
        operand_b_i = 32'd9;
        nextCycle();
        start_i = 1'b0;
        waitDone("t5", 16, 38, 22);
        checkOutput("t5_lo_const", 64'(lo_o), 64'd15);
        checkOutput("t5_idle_after", 64'(busy_o), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(MD_MULTU, 32'h1234, 32'h5678);
        repeat (9) nextCycle();
        reset_n_i = 1'b0;
        #1;
        checkOutput("t6_rst_hi", 64'(hi_o), 64'd0);
        checkOutput("t6_rst_lo", 64'(lo_o), 64'd0);
        checkOutput("t6_rst_flags", {61'b0, busy_o, done_o, div_by_zero_o}, 64'd0);
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        nextCycle();
        reset_n_i = 1'b1;
        nextCycle();
        checkOutput("t6_idle", 64'(busy_o), 64'd0);
        applyStimulus(MD_MULTU, 32'd6, 32'd7);
        waitDone("t6", 1, 33, 32);
        checkOutput("t6_lo_const", 64'(lo_o), 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
